// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-side sequencer for the 32x32 integer register file.
// Accepts ALU and load results over valid/ready, queues them in a circular
// FIFO and drains one register-file write per cycle. Reports pending writes
// to the operand-read stage as busy flags.
// Optional forwarding of queued data: define REGFILE_WB_FWD_EN.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            wb_hold,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            fwd1_valid,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_valid,
    output logic [XLEN-1:0] fwd2_data,
    output logic            wb_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      mem_rd_r   [DEPTH];
    logic [XLEN-1:0] mem_data_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    logic            deq_s;
    logic            space_s;
    logic            ld_x0_s;
    logic            alu_x0_s;
    logic            ld_take_s;
    logic            alu_take_s;
    logic            enq_s;
    logic [4:0]      enq_rd_s;
    logic [XLEN-1:0] enq_data_s;
    logic            rs1_busy_s;
    logic            rs2_busy_s;

    // The head leaves whenever something is queued and the write port is free.
    assign deq_s   = (count_r != {CW{1'b0}}) && !wb_hold;
    // A full queue that drains this cycle frees exactly one slot.
    assign space_s = (count_r < CW'(DEPTH)) || deq_s;

    // x0 results are accepted unconditionally and dropped.
    assign ld_x0_s  = ld_valid && (ld_rd == 5'd0);
    assign alu_x0_s = alu_valid && (alu_rd == 5'd0);

    // Load port has fixed priority; the ALU only gets a cycle with no load offer.
    assign ld_ready   = space_s || ld_x0_s;
    assign alu_ready  = !ld_valid && (space_s || alu_x0_s);
    assign ld_take_s  = ld_valid && (ld_rd != 5'd0) && space_s;
    assign alu_take_s = alu_valid && !ld_valid && (alu_rd != 5'd0) && space_s;
    assign enq_s      = ld_take_s || alu_take_s;
    assign enq_rd_s   = ld_take_s ? ld_rd : alu_rd;
    assign enq_data_s = ld_take_s ? ld_data : alu_data;

    // Write port shows the head entry; zeros when nothing is queued.
    assign wb_we   = deq_s;
    assign wb_rd   = (count_r != {CW{1'b0}}) ? mem_rd_r[rd_ptr_r]   : 5'd0;
    assign wb_data = (count_r != {CW{1'b0}}) ? mem_data_r[rd_ptr_r] : {XLEN{1'b0}};
    assign wb_idle = (count_r == {CW{1'b0}});

    // FIFO storage, pointers and occupancy; reset discards every queued entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_r[i]   <= 5'd0;
                mem_data_r[i] <= {XLEN{1'b0}};
            end
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                mem_rd_r[wr_ptr_r]   <= enq_rd_s;
                mem_data_r[wr_ptr_r] <= enq_data_s;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(enq_s) - CW'(deq_s);
        end
    end

    // Busy: any occupied entry (head included) targets the non-zero source.
    always_comb begin
        rs1_busy_s = 1'b0;
        rs2_busy_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            rs1_busy_s = rs1_busy_s | ((CW'(k) < count_r) && (rs1 != 5'd0) &&
                                       (mem_rd_r[rd_ptr_r + AW'(k)] == rs1));
            rs2_busy_s = rs2_busy_s | ((CW'(k) < count_r) && (rs2 != 5'd0) &&
                                       (mem_rd_r[rd_ptr_r + AW'(k)] == rs2));
        end
    end

    assign rs1_busy = rs1_busy_s;
    assign rs2_busy = rs2_busy_s;

`ifdef REGFILE_WB_FWD_EN
    logic [XLEN-1:0] fwd1_data_s;
    logic [XLEN-1:0] fwd2_data_s;

    // Forward data: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        fwd1_data_s = {XLEN{1'b0}};
        fwd2_data_s = {XLEN{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            fwd1_data_s = ((CW'(k) < count_r) && (rs1 != 5'd0) &&
                           (mem_rd_r[rd_ptr_r + AW'(k)] == rs1)) ?
                          mem_data_r[rd_ptr_r + AW'(k)] : fwd1_data_s;
            fwd2_data_s = ((CW'(k) < count_r) && (rs2 != 5'd0) &&
                           (mem_rd_r[rd_ptr_r + AW'(k)] == rs2)) ?
                          mem_data_r[rd_ptr_r + AW'(k)] : fwd2_data_s;
        end
    end

    assign fwd1_valid = rs1_busy_s;
    assign fwd1_data  = fwd1_data_s;
    assign fwd2_valid = rs2_busy_s;
    assign fwd2_data  = fwd2_data_s;
`else
    assign fwd1_valid = 1'b0;
    assign fwd1_data  = {XLEN{1'b0}};
    assign fwd2_valid = 1'b0;
    assign fwd2_data  = {XLEN{1'b0}};
`endif

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side sequencer for the 32x32 integer register file.
- Accepts results from two producers, the ALU and the load unit, over valid/ready, and buffers them in a small FIFO.
- Drives the register file's single write port (we, w, data_in) with one write per cycle.
- Reports to the operand-read stage whether a source register still has a queued, not-yet-written result (busy/hazard).

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- XLEN, 32, data width.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- ld_valid  in  1  load result offered
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load result
- ld_ready  out  1  load result accepted this cycle
- wb_hold  in  1  register-file write port unavailable this cycle
- wb_we  out  1  register-file write enable
- wb_rd  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- rs1  in  5  read-stage source 1
- rs2  in  5  read-stage source 2
- rs1_busy  out  1  queued write pending to rs1
- rs2_busy  out  1  queued write pending to rs2
- fwd1_valid  out  1  forward data valid for rs1
- fwd1_data  out  XLEN  forward data for rs1
- fwd2_valid  out  1  forward data valid for rs2
- fwd2_data  out  XLEN  forward data for rs2
- wb_idle  out  1  queue empty

Behaviour:
- Reset (resetn low, asynchronous):
  - Queue emptied; rd_ptr = wr_ptr = count = 0.
  - wb_we = 0, wb_rd = 0, wb_data = 0, wb_idle = 1.
  - All busy/fwd outputs 0.
  - Reset asserted mid-operation discards all queued entries; no write is issued after reset.
- Storage: circular FIFO with DEPTH entries of {rd[4:0], data[XLEN-1:0]}. count is $clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- Dequeue (deq):
  - deq = (count != 0) && !wb_hold.
  - wb_we = deq (combinational).
  - wb_rd and wb_data show the head entry whenever count != 0, and are 0 when the queue is empty.
  - The register file captures the write in the same cycle; rd_ptr advances at the clock edge.
- Space: space = (count < DEPTH) || deq. A full queue that is dequeuing in the same cycle accepts one new entry.
- Enqueue (one entry per cycle, fixed load priority):
  - ld_ready = space.
  - alu_ready = space && !ld_valid.
  - An accepted entry is written at wr_ptr on the clock edge, and wr_ptr advances.
- x0 filter:
  - An offered result with rd == 0 is always accepted (ready = 1, independent of space) and is discarded, not enqueued.
  - A discarded x0 result still blocks the ALU for that cycle if it came from the load port.
- count update: count_next = count + enq - deq, where enq = enqueue of a non-x0 entry. Simultaneous enq and deq leaves count unchanged.
- Latency:
  - A result accepted in cycle N appears on the write port in cycle N+1 at the earliest.
  - Each wb_hold cycle delays the write by one cycle.
- Ordering: writes leave in acceptance order. When two queued entries target the same rd, both are written, oldest first.
- Busy (combinational):
  - rsX_busy = 1 iff rsX != 0 and some occupied entry has rd == rsX.
  - The head entry counts as pending even while it is being written.
  - A result being enqueued in the current cycle does not count until the next cycle.
- wb_idle = (count == 0).

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined:
  - fwdX_valid = rsX_busy.
  - fwdX_data = data of the youngest occupied entry whose rd matches rsX. Search runs from wr_ptr-1 back toward rd_ptr, so younger entries win.
- Undefined:
  - fwdX_valid and fwdX_data are tied to 0.
  - The read stage must stall while rsX_busy is high.

Test Plan:
- Reset, then ALU offers rd=5, data 0xDEADBEEF with wb_hold=0 → alu_ready=1; next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; the cycle after, wb_idle=1.
- Hold wb_hold=1 and enqueue 4 ALU results (rd=1..4) → count reaches 4 and alu_ready=0 on the 5th offer. Release wb_hold → writes rd 1, 2, 3, 4 in order on consecutive cycles. A 5th offer made while releasing is accepted in the same cycle as the first dequeue.
- ld_valid and alu_valid both high (ld rd=7 data 0x11, alu rd=8 data 0x22) → ld_ready=1, alu_ready=0; ALU is accepted the following cycle; write order is 7 then 8.
- Offer rd=0 with data 0xFFFFFFFF from the ALU → alu_ready=1, count unchanged, wb_we stays 0, rs1=0 gives rs1_busy=0.
- With wb_hold=1, enqueue rd=9 data 0xA then rd=9 data 0xB; drive rs1=9, rs2=3 → rs1_busy=1, rs2_busy=0. With REGFILE_WB_FWD_EN defined, fwd1_data=0xB; without it, fwd1_valid=0.
- Assert resetn=0 asynchronously with 3 entries queued → wb_we drops immediately, wb_idle=1. After release there are no writes.
